drbg_key_slicer: RTL and testbench
==================================

# drbg_key_slicer

Downstream consumer of `hash_drbg` in the video-scrambler datapath. It requests 256-bit words from the DRBG over the `next`/`next_ready` handshake and holds them in a small word buffer. It hands out one KEY_W-bit scrambling key per video line on `line_start`, LSB slice first. The block decouples the DRBG's multi-cycle SHA-256 latency from the hard line-rate deadline of the decoder interface.

## Interface
- KEY_W, 16, key width in bits; must divide 256 (slices per word S = 256/KEY_W).
- DEPTH, 2, number of 256-bit words buffered (≥1).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- init_ready  in  1  DRBG instantiated; level, sampled.
- random_bits  in  256  DRBG output word; valid when `next_ready` rises.
- next_ready  in  1  DRBG word-ready; only its rising edge is significant.
- next  out  1  request level to DRBG; high while buffer space remains.
- line_start  in  1  one-cycle pulse per video line.
- key  out  KEY_W  registered key for current line.
- key_valid  out  1  one-cycle pulse, key delivered.
- underflow  out  1  sticky: a `line_start` found the buffer empty.
- level  out  $clog2(DEPTH+1)  words currently buffered.

## Operation
- Reset values: next=0, key=0, key_valid=0, underflow=0, level=0. Slice index is 0, read/write pointers are 0, armed=0, and the next_ready_d edge register is 0.
- FSM states:
  - IDLE: armed=0, next=0. Moves to FILL on the first cycle `init_ready`=1; armed stays set until reset.
  - FILL: next=1.
  - FULL: next=0.
  - FILL→FULL when the post-update count equals DEPTH.
  - FULL→FILL when the post-update count is less than DEPTH.
- Capture: `cap = next_ready & ~next_ready_d`. On `cap` with count<DEPTH, random_bits is written to wr_ptr, then wr_ptr++ (mod DEPTH) and count++.
- Capture while count==DEPTH (late in-flight word): the word is discarded; no state change.
- Slice: on `line_start` with count>0:
  - key ← word[rd_ptr][idx*KEY_W +: KEY_W]; key_valid=1; idx++.
  - If idx was S-1: idx←0, rd_ptr++ (mod DEPTH), count--.
- Underflow: on `line_start` with count==0, key holds its previous value, key_valid=0, underflow←1 (sticky).
- Simultaneous cap and word-retiring slice: the write and the pop both occur; count is unchanged. With count==DEPTH, the pop frees the slot in the same cycle, so the capture is accepted.
- Captures and line_starts are ignored in IDLE (not armed). The DRBG's `do_reseed` is not handled here.
- A reset mid-operation discards buffered words and the partial index; the FSM restarts in IDLE and waits for init_ready again.

## Timing
- next_ready rising at edge N: cap is seen at edge N+1 via next_ready_d. The word is sliceable from edge N+2, and level updates at edge N+2.
- line_start high at edge N: key/key_valid are valid after edge N+1 (one-cycle latency, registered).
- The `next` change follows the count change in the same cycle: it is registered from the next-state count, so it drops on the same edge the last slot fills.
- Back-to-back line_start on consecutive cycles is supported: one key per cycle.
- Throughput bound: the DRBG must deliver one word per S lines to avoid underflow.

## Test plan
- Reset, then init_ready=1, then DRBG returns 0x…1F1E…0100 (byte k = k): `next` drops after DEPTH=2 captures. First 16 line_starts yield keys 0x0100, 0x0302, …, 0x1F1E; level goes 2→1; `next` rises again.
- Exhaust the buffer with 33 line_starts and no DRBG response after the first 2 words: 32 keys valid, the 33rd gives key_valid=0, underflow=1, and key holds 0x1F1E.
- Hold the buffer full and pulse next_ready with 0xDEAD…: the word is discarded, level stays 2, and the following keys come from the original words.
- Same-cycle cap and 16th slice of word 0 with level=2: level stays 2, and the new word is read after word 1.
- Assert reset mid-word (idx=7, level=2): next cycle level=0, next=0, underflow=0, key=0. No `next` until init_ready is seen again.
- Before init_ready: pulses on next_ready and line_start produce next=0, level=0, key_valid=0, underflow=0.

Source files
------------

// File: rtl/drbg_key_slicer.sv
// drbg_key_slicer
//   Buffers 256-bit words from hash_drbg and hands out one KEY_W-bit
//   scrambling key per video line, least-significant slice first. Hides the
//   DRBG's multi-cycle latency behind a DEPTH-word buffer so the line-rate
//   key deadline is met.
//
// Ports
//   clk          in   single clock, posedge
//   reset        in   synchronous active-high reset
//   init_ready   in   DRBG instantiated (level); arms the block
//   random_bits  in   256-bit DRBG word, taken on the rising edge of next_ready
//   next_ready   in   DRBG word-ready; only its rising edge matters
//   next         out  request level to the DRBG, high while a slot is free
//   line_start   in   one-cycle pulse per video line
//   key          out  registered key for the current line
//   key_valid    out  one-cycle pulse when a key is delivered
//   underflow    out  sticky: a line_start found the buffer empty
//   level        out  number of buffered words
module drbg_key_slicer #(
  parameter int KEY_W = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_ready,
  input  logic [255:0]               random_bits,
  input  logic                       next_ready,
  output logic                       next,
  input  logic                       line_start,
  output logic [KEY_W-1:0]           key,
  output logic                       key_valid,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int S     = 256 / KEY_W;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t             state;
  logic               nr_d;
  logic               vld_p0;
  logic [255:0]       word_p0;
  logic [255:0]       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [IDX_W-1:0]   idx;

  logic               armed;
  logic               slice;
  logic               pop;
  logic               push;
  logic [LVL_W-1:0]   level_nxt;
  logic [255:0]       rd_word;
  logic [7:0]         off;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    armed     = (state != IDLE);
    slice     = armed && line_start && (level != '0);
    pop       = slice && (idx == IDX_W'(S - 1));
    // A retiring slice frees its slot in the same cycle, so a full buffer
    // can still accept the word that arrives on that edge.
    push      = armed && vld_p0 && ((level != LVL_W'(DEPTH)) || pop);
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (pop && !push) level_nxt = level - 1'b1;
    rd_word   = mem[rd_ptr];
    off       = 8'(32'(idx) * KEY_W);
  end

  // Stage p0: detect the next_ready rising edge and hold the word beside it
  always_ff @(posedge clk) begin
    if (reset) begin
      nr_d   <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      nr_d   <= next_ready;
      vld_p0 <= next_ready & ~nr_d;
    end
  end

  always_ff @(posedge clk) begin
    word_p0 <= random_bits;
  end

  // Stage p1: buffer write, slice read and request FSM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      next      <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      underflow <= 1'b0;
      level     <= '0;
      idx       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      key_valid <= slice;
      if (slice) begin
        key <= rd_word[off +: KEY_W];
        if (pop) begin
          idx    <= '0;
          rd_ptr <= ptr_inc(rd_ptr);
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (armed && line_start && (level == '0)) underflow <= 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      level <= level_nxt;

      // next is registered from the post-update count so it drops on the
      // same edge the last slot fills.
      case (state)
        IDLE: begin
          if (init_ready) begin
            state <= FILL;
            next  <= 1'b1;
          end
        end
        FILL: begin
          if (level_nxt == LVL_W'(DEPTH)) begin
            state <= FULL;
            next  <= 1'b0;
          end else begin
            next  <= 1'b1;
          end
        end
        FULL: begin
          if (level_nxt < LVL_W'(DEPTH)) begin
            state <= FILL;
            next  <= 1'b1;
          end else begin
            next  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          next  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drbg_key_slicer.sv
// Testbench for drbg_key_slicer: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_drbg_key_slicer;
  localparam int KEY_W = 16;
  localparam int DEPTH = 2;
  localparam int S     = 256 / KEY_W;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset, init_ready, next_ready, line_start;
  logic [255:0]       random_bits;
  logic               next, key_valid, underflow;
  logic [KEY_W-1:0]   key;
  logic [LVL_W-1:0]   level;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [255:0]     q[$];
  int               m_idx;
  logic             m_armed, m_nr_prev, m_pend, m_kv, m_uf;
  logic [255:0]     m_pend_word;
  logic [KEY_W-1:0] m_key;

  always #5 clk = ~clk;

  drbg_key_slicer #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .init_ready(init_ready),
    .random_bits(random_bits), .next_ready(next_ready), .next(next),
    .line_start(line_start), .key(key), .key_valid(key_valid),
    .underflow(underflow), .level(level)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int n;
    logic slice, pop, acc;
    logic [255:0] w;
    if (reset) begin
      q.delete();
      m_idx = 0; m_armed = 0; m_nr_prev = 0; m_pend = 0;
      m_kv = 0; m_uf = 0; m_key = '0;
    end else begin
      n     = q.size();
      slice = m_armed && line_start && (n > 0);
      pop   = slice && (m_idx == S - 1);
      acc   = m_armed && m_pend && ((n < DEPTH) || pop);
      m_kv  = slice;
      if (m_armed && line_start && (n == 0)) m_uf = 1'b1;
      if (slice) begin
        w     = q[0] >> (m_idx * KEY_W);
        m_key = w[KEY_W-1:0];
        m_idx++;
        if (pop) begin
          void'(q.pop_front());
          m_idx = 0;
        end
      end
      if (acc) q.push_back(m_pend_word);
      m_pend      = next_ready && !m_nr_prev;
      m_pend_word = random_bits;
      m_nr_prev   = next_ready;
      if (!m_armed && init_ready) m_armed = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 256'(level), 256'(q.size()));
    chk("next", 256'(next), 256'(m_armed && (q.size() < DEPTH)));
    chk("key_valid", 256'(key_valid), 256'(m_kv));
    chk("key", 256'(key), 256'(m_key));
    chk("underflow", 256'(underflow), 256'(m_uf));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic lines(input int n);
    line_start = 1'b1;
    repeat (n) tick();
    line_start = 1'b0;
  endtask

  task automatic drbg(input logic [255:0] w);
    random_bits = w;
    next_ready  = 1'b1;
    tick();
    next_ready  = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [255:0] pat;
    logic [255:0] dead;
    for (int k = 0; k < 32; k++) pat[k*8 +: 8] = 8'(k);
    for (int k = 0; k < 16; k++) dead[k*16 +: 16] = 16'hDEAD;

    reset = 1'b1; init_ready = 1'b0; next_ready = 1'b0; line_start = 1'b0;
    random_bits = '0;
    ticks(2);
    chk("rst_level", 256'(level), 256'(0));
    chk("rst_next", 256'(next), 256'(0));
    reset = 1'b0;

    // not armed: DRBG words and line pulses are ignored
    drbg(rnd256());
    lines(2);
    drbg(rnd256());
    ticks(2);
    chk("idle_level", 256'(level), 256'(0));
    chk("idle_uf", 256'(underflow), 256'(0));

    // arm and fill with the byte-ramp pattern
    init_ready = 1'b1;
    tick();
    chk("armed_next", 256'(next), 256'(1));
    drbg(pat);
    drbg(pat);
    chk("full_next", 256'(next), 256'(0));
    chk("full_level", 256'(level), 256'(2));

    line_start = 1'b1;
    for (int i = 0; i < S; i++) begin
      tick();
      chk("pat_key", 256'(key), 256'({8'(2*i+1), 8'(2*i)}));
    end
    line_start = 1'b0;
    tick();
    chk("after16_level", 256'(level), 256'(1));
    chk("after16_next", 256'(next), 256'(1));

    // exhaust: 16 more valid keys, then an underflow that holds the key
    lines(S + 1);
    chk("uf_kv", 256'(key_valid), 256'(0));
    chk("uf_flag", 256'(underflow), 256'(1));
    chk("uf_key_hold", 256'(key), 256'(16'h1F1E));

    // full buffer discards a late word
    drbg(rnd256());
    drbg(rnd256());
    drbg(dead);
    chk("discard_level", 256'(level), 256'(2));

    // capture lands on the same edge as the 16th slice of the head word
    line_start = 1'b1;
    ticks(S - 2);
    random_bits = rnd256();
    next_ready  = 1'b1;
    tick();
    next_ready  = 1'b0;
    tick();
    line_start  = 1'b0;
    chk("simul_level", 256'(level), 256'(2));
    lines(2 * S);

    // reset in the middle of a word
    drbg(rnd256());
    drbg(rnd256());
    lines(7);
    reset = 1'b1; init_ready = 1'b0;
    tick();
    reset = 1'b0;
    chk("mrst_level", 256'(level), 256'(0));
    chk("mrst_next", 256'(next), 256'(0));
    chk("mrst_uf", 256'(underflow), 256'(0));
    chk("mrst_key", 256'(key), 256'(0));
    drbg(rnd256());
    lines(3);
    chk("mrst_idle_next", 256'(next), 256'(0));
    init_ready = 1'b1;
    tick();

    // randomized traffic: consumer-heavy then producer-heavy
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 400; c++) begin
        random_bits = rnd256();
        line_start  = (ph == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
        next_ready  = (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 199) == 0) reset = 1'b1;
        tick();
        reset = 1'b0;
        init_ready = 1'b1;
      end
    end
    line_start = 1'b0;
    next_ready = 1'b0;
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
